// File: rtl/result_hex_tx.sv
// Serialises a captured 16-bit word as the ASCII line "0xHHHH\r\n" on an 8N1 UART.
// Each start pulse produces one line, and busy/done form the handshake with the control FSM.
module result_hex_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        UART_TXD
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    char_idx;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud;
  logic [15:0]   word;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) begin
      hex_ascii = 8'h30 + {4'h0, n};
    end else begin
      hex_ascii = 8'h37 + {4'h0, n};  // 0x41 + (n - 10)
    end
  endfunction

  function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [15:0] w);
    case (idx)
      3'd0:    char_at = 8'h30;
      3'd1:    char_at = 8'h78;
      3'd2:    char_at = hex_ascii(w[15:12]);
      3'd3:    char_at = hex_ascii(w[11:8]);
      3'd4:    char_at = hex_ascii(w[7:4]);
      3'd5:    char_at = hex_ascii(w[3:0]);
      3'd6:    char_at = 8'h0D;
      3'd7:    char_at = 8'h0A;
      default: char_at = 8'h0A;
    endcase
  endfunction

  // Byte being sent, taken from the captured word so later changes on value are ignored.
  always_comb begin
    cur_byte = char_at(char_idx, word);
  end

  // Line FSM. The serial line is driven one cycle ahead so every output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      char_idx <= 3'd0;
      bit_idx  <= 3'd0;
      baud     <= BAUD_ZERO;
      word     <= 16'h0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      UART_TXD <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          baud <= BAUD_ZERO;
          if (start) begin
            word     <= value;
            char_idx <= 3'd0;
            bit_idx  <= 3'd0;
            busy     <= 1'b1;
            UART_TXD <= 1'b0;
            state    <= START;
          end else begin
            busy     <= 1'b0;
            UART_TXD <= 1'b1;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud     <= BAUD_ZERO;
            bit_idx  <= 3'd0;
            UART_TXD <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= BAUD_ZERO;
            if (bit_idx == 3'd7) begin
              UART_TXD <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              UART_TXD <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= BAUD_ZERO;
            if (char_idx != 3'd7) begin
              char_idx <= char_idx + 3'd1;
              UART_TXD <= 1'b0;
              state    <= START;
            end else begin
              busy     <= 1'b0;
              done     <= 1'b1;
              UART_TXD <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end
        default: begin
          baud     <= BAUD_ZERO;
          busy     <= 1'b0;
          UART_TXD <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_hex_tx.sv
// Scoreboard bench for result_hex_tx: stimulus pushes hand-computed bytes and done times,
// and a UART monitor decodes the serial line and pops from the queues to compare.
module tb_result_hex_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        busy;
  logic        done;
  logic        txd;

  typedef struct {
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t byte_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_e0 = 0;

  // Monitor state.
  bit         in_frame = 1'b0;
  int         k = 0;
  int         f_at = 0;
  int         j = 0;
  logic [7:0] sh = 8'h00;
  exp_t       e;

  result_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .UART_TXD (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
  endtask

  task automatic wait_cyc(input int n);
    do begin
      @(posedge clk);
      #2;
    end while (cyc < n);
  endtask

  // Called 2 time units after a rising edge; the next edge accepts the line.
  task automatic send(input logic [15:0] v, input logic [63:0] exp);
    value   = v;
    start   = 1'b1;
    last_e0 = cyc + 1;
    for (int i = 0; i < 8; i++)
      byte_q.push_back('{b: exp[63-8*i -: 8], at: last_e0 + 10*CPB*i});
    done_q.push_back(last_e0 + 80*CPB);
    @(posedge clk);
    #2;
    start = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_txd", {31'd0, txd}, 32'd0);
  endtask

  // UART decoder and done monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_frame = 1'b0;
      end else begin
        if (done) begin
          if (done_q.size() == 0) begin
            n_checks++;
            $display("FAIL done_extra: got done at cycle %0d expected none", cyc);
          end else begin
            check("done_cycle", cyc, done_q.pop_front());
          end
        end
        if (!in_frame) begin
          if (txd == 1'b0) begin
            in_frame = 1'b1;
            k        = 0;
            f_at     = cyc;
          end
        end else begin
          k++;
          if (k % CPB == CPB/2) begin
            j = k / CPB;
            if (j == 0) begin
              check("start_bit", {31'd0, txd}, 32'd0);
            end else if (j <= 8) begin
              sh[j-1] = txd;
            end else begin
              check("stop_bit", {31'd0, txd}, 32'd1);
              if (byte_q.size() == 0) begin
                n_checks++;
                $display("FAIL byte_extra: got byte 0x%0h at cycle %0d expected none", sh, f_at);
              end else begin
                e = byte_q.pop_front();
                check("byte_value", {24'd0, sh}, {24'd0, e.b});
                check("byte_start_cycle", f_at, e.at);
              end
            end
          end
          if (k == 10*CPB - 1) in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    wait_cyc(cyc + 3);

    // Basic line
    send(16'h1234, 64'h30_78_31_32_33_34_0D_0A);
    wait_cyc(last_e0 + 330);

    // Hex letters
    send(16'hABCF, 64'h30_78_41_42_43_46_0D_0A);
    wait_cyc(last_e0 + 330);

    // 9/A boundary and zero digits
    send(16'h09A0, 64'h30_78_30_39_41_30_0D_0A);
    wait_cyc(last_e0 + 330);

    // start and value changes while busy are ignored
    send(16'h1234, 64'h30_78_31_32_33_34_0D_0A);
    e0 = last_e0;
    wait_cyc(e0 + 50);
    value = 16'hFFFF;
    start = 1'b1;
    check("busy_mid_line", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_cyc(e0 + 430);

    // Back-to-back: the second start arrives in the done cycle
    send(16'h1234, 64'h30_78_31_32_33_34_0D_0A);
    e0 = last_e0;
    wait_cyc(e0 + 320);
    check("b2b_done_high", {31'd0, done}, 32'd1);
    check("b2b_busy_low", {31'd0, busy}, 32'd0);
    send(16'hBEEF, 64'h30_78_42_45_45_46_0D_0A);
    check("b2b_e0", last_e0, e0 + 321);
    wait_cyc(last_e0 + 330);

    // Reset during the data bits of character 3
    send(16'h1234, 64'h30_78_31_32_33_34_0D_0A);
    e0 = last_e0;
    wait_cyc(e0 + 130);
    rst = 1'b0;
    #1;
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_chars_seen", byte_q.size(), 32'd5);
    byte_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    wait_cyc(cyc + 5);
    send(16'h0001, 64'h30_78_30_30_30_31_0D_0A);
    wait_cyc(last_e0 + 400);

    check("byte_q_drained", byte_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
